// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and PID constants for the USB receive controller
package usb_rx_pkg;

  // Receive sequencer states; one per field plus the two one-cycle check slots
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SYNC     = 4'd1,
    ST_CHK_SYNC = 4'd2,
    ST_PID      = 4'd3,
    ST_CHK_PID  = 4'd4,
    ST_SKIP     = 4'd5,
    ST_CRC5     = 4'd6,
    ST_DATA     = 4'd7,
    ST_CRC16    = 4'd8,
    ST_WAIT_EOP = 4'd9,
    ST_DONE     = 4'd10,
    ST_ERR      = 4'd11
  } rcv_state_t;

  typedef enum logic [1:0] {
    PKT_NONE      = 2'b00,
    PKT_TOKEN     = 2'b01,
    PKT_DATA      = 2'b10,
    PKT_HANDSHAKE = 2'b11
  } pkt_type_t;

  localparam int unsigned CNT_W = 7;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Classify a received PID byte; a broken complement check or an unsupported code yields PKT_NONE
  function automatic pkt_type_t pid_class(input logic [7:0] pid);
    pkt_type_t t;
    t = PKT_NONE;
    if (pid[3:0] == ~pid[7:4]) begin
      case (pid[3:0])
        PID_OUT, PID_IN, PID_SETUP:   t = PKT_TOKEN;
        PID_DATA0, PID_DATA1:         t = PKT_DATA;
        PID_ACK, PID_NAK, PID_STALL:  t = PKT_HANDSHAKE;
        default:                      t = PKT_NONE;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable bit counter with programmable rollover value
module flex_counter #(
  parameter int unsigned NUM_BITS = 7
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic                rollover_flag
);

  logic [NUM_BITS-1:0] count_q;
  logic [NUM_BITS-1:0] count_d;

  // Clear wins over counting so a field end and the next field's restart share one edge
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rcv_shift_controller.sv
// rtl/rcv_shift_controller.sv - routes decoded USB bits to the sync/PID/CRC/data field registers
module rcv_shift_controller
  import usb_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS       = 64,
  parameter int unsigned TOKEN_SKIP_BITS = 11,
  parameter logic [7:0]  SYNC_PATTERN    = SYNC_BYTE
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_rcv,
  input  logic       shift_strobe,
  input  logic       eop,
  input  logic [7:0] rcv_sync,
  input  logic [7:0] rcv_pid,
  output logic       sync_shift_enable,
  output logic       pid_shift_enable,
  output logic       crc5_shift_enable,
  output logic       crc16_shift_enable,
  output logic       data_shift_enable,
  output logic       rcving,
  output logic       packet_done,
  output logic       rcv_error,
  output logic [1:0] pkt_type
);

  localparam logic [CNT_W-1:0] BYTE_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] SKIP_LAST  = CNT_W'(TOKEN_SKIP_BITS - 1);
  localparam logic [CNT_W-1:0] CRC5_LAST  = CNT_W'(4);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CRC16_LAST = CNT_W'(15);

  rcv_state_t       state_q, state_d;
  logic             err_q, err_d;
  pkt_type_t        type_q, type_d;

  logic [CNT_W-1:0] roll_val;
  logic             roll_flag;
  logic             cnt_en;
  logic             cnt_clear;
  pkt_type_t        pid_type;

  assign pid_type = pid_class(rcv_pid);

  flex_counter #(
    .NUM_BITS (CNT_W)
  ) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .count_enable  (cnt_en),
    .rollover_val  (roll_val),
    .rollover_flag (roll_flag)
  );

  // Next-state, field length selection and Mealy enable decode; eop always beats shift_strobe
  always_comb begin
    state_d            = state_q;
    err_d              = err_q;
    type_d             = type_q;
    roll_val           = '0;
    cnt_en             = 1'b0;
    sync_shift_enable  = 1'b0;
    pid_shift_enable   = 1'b0;
    crc5_shift_enable  = 1'b0;
    crc16_shift_enable = 1'b0;
    data_shift_enable  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_rcv) begin
          state_d = ST_SYNC;
          err_d   = 1'b0;
          type_d  = PKT_NONE;
        end
      end
      ST_SYNC: begin
        roll_val = BYTE_LAST;
        if (eop) begin
          state_d = ST_ERR;
        end else if (shift_strobe) begin
          sync_shift_enable = 1'b1;
          cnt_en            = 1'b1;
          if (roll_flag) state_d = ST_CHK_SYNC;
        end
      end
      ST_CHK_SYNC: begin
        if (eop || shift_strobe) begin
          state_d = ST_ERR;
        end else begin
          state_d = (rcv_sync == SYNC_PATTERN) ? ST_PID : ST_ERR;
        end
      end
      ST_PID: begin
        roll_val = BYTE_LAST;
        if (eop) begin
          state_d = ST_ERR;
        end else if (shift_strobe) begin
          pid_shift_enable = 1'b1;
          cnt_en           = 1'b1;
          if (roll_flag) state_d = ST_CHK_PID;
        end
      end
      ST_CHK_PID: begin
        if (eop || shift_strobe) begin
          state_d = ST_ERR;
        end else begin
          type_d = pid_type;
          case (pid_type)
            PKT_TOKEN:     state_d = ST_SKIP;
            PKT_DATA:      state_d = ST_DATA;
            PKT_HANDSHAKE: state_d = ST_WAIT_EOP;
            default:       state_d = ST_ERR;
          endcase
        end
      end
      ST_SKIP: begin
        roll_val = SKIP_LAST;
        if (eop) begin
          state_d = ST_ERR;
        end else if (shift_strobe) begin
          cnt_en = 1'b1;
          if (roll_flag) state_d = ST_CRC5;
        end
      end
      ST_CRC5: begin
        roll_val = CRC5_LAST;
        if (eop) begin
          state_d = ST_ERR;
        end else if (shift_strobe) begin
          crc5_shift_enable = 1'b1;
          cnt_en            = 1'b1;
          if (roll_flag) state_d = ST_WAIT_EOP;
        end
      end
      ST_DATA: begin
        roll_val = DATA_LAST;
        if (eop) begin
          state_d = ST_ERR;
        end else if (shift_strobe) begin
          data_shift_enable = 1'b1;
          cnt_en            = 1'b1;
          if (roll_flag) state_d = ST_CRC16;
        end
      end
      ST_CRC16: begin
        roll_val = CRC16_LAST;
        if (eop) begin
          state_d = ST_ERR;
        end else if (shift_strobe) begin
          crc16_shift_enable = 1'b1;
          cnt_en             = 1'b1;
          if (roll_flag) state_d = ST_WAIT_EOP;
        end
      end
      ST_WAIT_EOP: begin
        if (eop) begin
          state_d = ST_DONE;
        end else if (shift_strobe) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (!eop) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_ERR) err_d = 1'b1;
  end

  // Restart the bit count whenever a new field (or any other state) is entered
  assign cnt_clear = (state_d != state_q);

  // State, sticky error flag and packet type registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      type_q  <= PKT_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      type_q  <= type_d;
    end
  end

  assign rcving      = (state_q != ST_IDLE);
  assign packet_done = (state_q == ST_DONE);
  assign rcv_error   = err_q;
  assign pkt_type    = type_q;

endmodule

// File: tb/tb_rcv_shift_controller.sv
// tb/tb_rcv_shift_controller.sv - self-checking bench for rcv_shift_controller
module tb_rcv_shift_controller;

  localparam int DB   = 64;
  localparam int SKIP = 11;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start_rcv;
  logic       shift_strobe;
  logic       eop;
  logic [7:0] rcv_sync;
  logic [7:0] rcv_pid;
  logic       sync_shift_enable;
  logic       pid_shift_enable;
  logic       crc5_shift_enable;
  logic       crc16_shift_enable;
  logic       data_shift_enable;
  logic       rcving;
  logic       packet_done;
  logic       rcv_error;
  logic [1:0] pkt_type;

  int n_cmp = 0;
  int n_bad = 0;
  int c_sync, c_pid, c_crc5, c_crc16, c_data, c_done, c_multi;

  rcv_shift_controller dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .start_rcv          (start_rcv),
    .shift_strobe       (shift_strobe),
    .eop                (eop),
    .rcv_sync           (rcv_sync),
    .rcv_pid            (rcv_pid),
    .sync_shift_enable  (sync_shift_enable),
    .pid_shift_enable   (pid_shift_enable),
    .crc5_shift_enable  (crc5_shift_enable),
    .crc16_shift_enable (crc16_shift_enable),
    .data_shift_enable  (data_shift_enable),
    .rcving             (rcving),
    .packet_done        (packet_done),
    .rcv_error          (rcv_error),
    .pkt_type           (pkt_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic clear_counts();
    c_sync = 0; c_pid = 0; c_crc5 = 0; c_crc16 = 0; c_data = 0; c_done = 0; c_multi = 0;
  endtask

  // One clock cycle: drive inputs, sample Mealy outputs mid-cycle, then move past the edge
  task automatic step(input logic ss, input logic e);
    int n_en;
    shift_strobe = ss;
    eop          = e;
    #1;
    n_en = int'(sync_shift_enable) + int'(pid_shift_enable) + int'(crc5_shift_enable)
         + int'(crc16_shift_enable) + int'(data_shift_enable);
    c_sync  += int'(sync_shift_enable);
    c_pid   += int'(pid_shift_enable);
    c_crc5  += int'(crc5_shift_enable);
    c_crc16 += int'(crc16_shift_enable);
    c_data  += int'(data_shift_enable);
    c_done  += int'(packet_done);
    if (n_en > 1) c_multi++;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int lo, input int hi);
    repeat ($urandom_range(hi, lo)) step(1'b0, 1'b0);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Send one packet: SYNC byte, PID byte, nbody further bits, then eop. If ewl, the last body bit
  // arrives together with eop and must be discarded. Expectations come from field-length arithmetic.
  task automatic send_packet(input logic [7:0] sync, input logic [7:0] pid, input int nbody,
                             input bit ewl);
    logic [3:0] lo, hi;
    bit  sync_ok, hdr_ok;
    int  ptype, need, eff;
    int  e_pid, e_crc5, e_crc16, e_data, e_type;
    bit  e_done;

    sync_ok = (sync == 8'h80);
    lo = pid[3:0];
    hi = pid[7:4];
    ptype = 0;
    need  = 0;
    if (lo == ~hi) begin
      case (lo)
        4'h1, 4'h9, 4'hD: begin ptype = 1; need = SKIP + 5; end
        4'h3, 4'hB:       begin ptype = 2; need = DB + 16;  end
        4'h2, 4'hA, 4'hE: begin ptype = 3; need = 0;        end
        default:          ptype = 0;
      endcase
    end
    eff     = nbody - (ewl ? 1 : 0);
    hdr_ok  = sync_ok && (ptype != 0);
    e_type  = sync_ok ? ptype : 0;
    e_pid   = sync_ok ? 8 : 0;
    e_crc5  = (hdr_ok && ptype == 1) ? clampi(eff - SKIP, 0, 5) : 0;
    e_data  = (hdr_ok && ptype == 2) ? clampi(eff, 0, DB) : 0;
    e_crc16 = (hdr_ok && ptype == 2) ? clampi(eff - DB, 0, 16) : 0;
    e_done  = hdr_ok && (eff == need);

    rcv_sync = sync;
    rcv_pid  = pid;
    clear_counts();

    start_rcv = 1'b1;
    step(1'b0, 1'b0);
    start_rcv = 1'b0;
    check("start_rcving", 32'(rcving), 32'd1);
    check("start_err_clr", 32'(rcv_error), 32'd0);
    check("start_type_clr", 32'(pkt_type), 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      if (i == 7) begin
        step(1'b0, 1'b0);
        check("err_after_chk_sync", 32'(rcv_error), 32'(!sync_ok));
        gap(0, 2);
      end else begin
        gap(1, 3);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      if (i == 7) begin
        step(1'b0, 1'b0);
        check("err_after_chk_pid", 32'(rcv_error), 32'(!hdr_ok));
        check("type_after_chk_pid", 32'(pkt_type), 32'(e_type));
        gap(0, 2);
      end else begin
        gap(1, 3);
      end
    end
    for (int i = 0; i < nbody; i++) begin
      if (ewl && i == nbody - 1) begin
        step(1'b1, 1'b1);
      end else begin
        step(1'b1, 1'b0);
        gap(1, 3);
      end
    end
    repeat (2) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);

    check("sync_en_count", 32'(c_sync), 32'd8);
    check("pid_en_count", 32'(c_pid), 32'(e_pid));
    check("crc5_en_count", 32'(c_crc5), 32'(e_crc5));
    check("data_en_count", 32'(c_data), 32'(e_data));
    check("crc16_en_count", 32'(c_crc16), 32'(e_crc16));
    check("done_pulses", 32'(c_done), 32'(e_done));
    check("end_rcv_error", 32'(rcv_error), 32'(!e_done));
    check("end_pkt_type", 32'(pkt_type), 32'(e_type));
    check("end_rcving", 32'(rcving), 32'd0);
    check("enable_onehot", 32'(c_multi), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {23'd0, sync_shift_enable, pid_shift_enable, crc5_shift_enable, crc16_shift_enable,
                data_shift_enable, rcving, packet_done, rcv_error, |pkt_type}, 32'd0);
  endtask

  initial begin
    int kind, need, nbody;
    logic [7:0] pid, sync;
    logic [7:0] tok_pids [3];
    logic [7:0] dat_pids [2];
    logic [7:0] hs_pids  [3];
    tok_pids = '{8'h69, 8'hE1, 8'h2D};
    dat_pids = '{8'hC3, 8'h4B};
    hs_pids  = '{8'hD2, 8'h5A, 8'h1E};

    n_rst        = 1'b0;
    start_rcv    = 1'b0;
    shift_strobe = 1'b0;
    eop          = 1'b0;
    rcv_sync     = 8'h00;
    rcv_pid      = 8'h00;
    #2;
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(1'b0, 1'b0);
    check_all_zero("idle_after_reset");

    send_packet(8'h80, 8'hC3, DB + 16, 1'b0);
    send_packet(8'h80, 8'h69, SKIP + 5, 1'b0);
    send_packet(8'h80, 8'hD2, 0, 1'b0);
    send_packet(8'h80, 8'hD2, 1, 1'b0);
    send_packet(8'h81, 8'hC3, DB + 16, 1'b0);
    send_packet(8'h80, 8'h11, 16, 1'b0);
    send_packet(8'h80, 8'hC3, 30, 1'b0);
    send_packet(8'h80, 8'hC3, DB + 16, 1'b1);
    send_packet(8'h80, 8'hD2, 1, 1'b1);
    send_packet(8'h80, 8'h69, SKIP + 5, 1'b1);

    // Asynchronous reset in the middle of the data field, with a strobe in flight
    rcv_sync = 8'h80;
    rcv_pid  = 8'hC3;
    start_rcv = 1'b1;
    step(1'b0, 1'b0);
    start_rcv = 1'b0;
    for (int i = 0; i < 26; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    shift_strobe = 1'b1;
    #1;
    check("data_en_before_reset", 32'(data_shift_enable), 32'd1);
    #1;
    n_rst = 1'b0;
    #1;
    check_all_zero("async_reset_mid_data");
    @(posedge clk);
    #1;
    shift_strobe = 1'b0;
    n_rst        = 1'b1;
    step(1'b0, 1'b0);
    send_packet(8'h80, 8'hC3, DB + 16, 1'b0);

    for (int p = 0; p < 30; p++) begin
      kind = int'($urandom_range(3, 0));
      sync = ($urandom_range(7, 0) == 0) ? 8'($urandom()) : 8'h80;
      case (kind)
        0:       begin pid = tok_pids[$urandom_range(2, 0)]; need = SKIP + 5; end
        1:       begin pid = dat_pids[$urandom_range(1, 0)]; need = DB + 16;  end
        2:       begin pid = hs_pids[$urandom_range(2, 0)];  need = 0;        end
        default: begin pid = 8'($urandom());                 need = 8;        end
      endcase
      if ($urandom_range(1, 0) == 0) nbody = need;
      else nbody = clampi(need + int'($urandom_range(4, 0)) - 2, 0, 200);
      send_packet(sync, pid, nbody, (nbody > 0) && ($urandom_range(3, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
